// File: rtl/ram_request_arbiter_if.sv
// Bus bundle between the per-core cache controllers, the RAM request arbiter and the RAM model.
// The master modport is the arbiter's view; the slave modport is the view of the cores and RAM around it.
interface ram_request_arbiter_if #(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    localparam int GW = $clog2((CPUS > 2) ? CPUS : 2);

    logic [CPUS-1:0]    iREN;
    logic [CPUS-1:0]    dREN;
    logic [CPUS-1:0]    dWEN;
    logic [CPUS*AW-1:0] iaddr;
    logic [CPUS*AW-1:0] daddr;
    logic [CPUS*DW-1:0] dstore;
    logic [CPUS-1:0]    iwait;
    logic [CPUS-1:0]    dwait;
    logic [DW-1:0]      iload;
    logic [DW-1:0]      dload;

    logic               ramREN;
    logic               ramWEN;
    logic [AW-1:0]      ramaddr;
    logic [DW-1:0]      ramstore;
    logic [DW-1:0]      ramload;
    logic [1:0]         ramstate;

    logic               grant_valid;
    logic [GW-1:0]      grant_cpu;
    logic               grant_data;

    modport master (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               grant_valid, grant_cpu, grant_data
    );

    modport slave (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               grant_valid, grant_cpu, grant_data
    );
endinterface

// File: rtl/ram_request_arbiter.sv
// Registered-grant arbiter sharing one RAM port among CPUS cores: round-robin across cores,
// data before instruction fetch within a core, one transfer held until the RAM reports ACCESS.
module ram_request_arbiter #(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input logic                   CLK,
    input logic                   nRST,
    ram_request_arbiter_if.master bus
);
    localparam int GW = $clog2((CPUS > 2) ? CPUS : 2);

    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, GRANT, ERR} state_t;

    state_t        state, state_n;
    logic          gnt_valid, gnt_valid_n;
    logic [GW-1:0] gnt_cpu, gnt_cpu_n;
    logic          gnt_data, gnt_data_n;
    logic [GW-1:0] rr_ptr, rr_ptr_n;

    ramstate_t     ram_st;
    logic          win_found;
    logic [GW-1:0] win_cpu;
    logic          win_data;
    int            scan_idx;
    logic [GW-1:0] scan_cpu;

    logic [AW-1:0] own_iaddr, own_daddr;
    logic [DW-1:0] own_dstore;
    logic          own_iren, own_dren, own_dwen, own_req;

    assign ram_st = ramstate_t'(bus.ramstate);

    // Scan cores starting at rr_ptr; the first core with any pending request wins.
    always_comb begin
        win_found = 1'b0;
        win_cpu   = '0;
        win_data  = 1'b0;
        scan_idx  = 0;
        scan_cpu  = '0;
        for (int k = 0; k < CPUS; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= CPUS) scan_idx = scan_idx - CPUS;
            scan_cpu = GW'(scan_idx);
            if (!win_found && (bus.dREN[scan_cpu] || bus.dWEN[scan_cpu] || bus.iREN[scan_cpu])) begin
                win_found = 1'b1;
                win_cpu   = scan_cpu;
                win_data  = bus.dREN[scan_cpu] | bus.dWEN[scan_cpu];
            end
        end
    end

    assign own_iaddr  = bus.iaddr[int'(gnt_cpu)*AW +: AW];
    assign own_daddr  = bus.daddr[int'(gnt_cpu)*AW +: AW];
    assign own_dstore = bus.dstore[int'(gnt_cpu)*DW +: DW];
    assign own_iren   = bus.iREN[gnt_cpu];
    assign own_dren   = bus.dREN[gnt_cpu];
    assign own_dwen   = bus.dWEN[gnt_cpu];
    assign own_req    = gnt_data ? (own_dren | own_dwen) : own_iren;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n      = state;
        gnt_valid_n  = gnt_valid;
        gnt_cpu_n    = gnt_cpu;
        gnt_data_n   = gnt_data;
        rr_ptr_n     = rr_ptr;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = '1;
        bus.dwait    = '1;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n     = GRANT;
                    gnt_valid_n = 1'b1;
                    gnt_cpu_n   = win_cpu;
                    gnt_data_n  = win_data;
                end
            end
            GRANT: begin
                // RAM signals follow the owner's live inputs; a write wins over a read.
                if (gnt_data) begin
                    bus.ramaddr = own_daddr;
                    if (own_dwen) begin
                        bus.ramWEN   = 1'b1;
                        bus.ramstore = own_dstore;
                    end else begin
                        bus.ramREN = own_dren;
                    end
                end else begin
                    bus.ramaddr = own_iaddr;
                    bus.ramREN  = own_iren;
                end

                if (!own_req) begin
                    state_n     = IDLE;
                    gnt_valid_n = 1'b0;
                end else if (ram_st == RAM_ACCESS) begin
                    if (gnt_data) bus.dwait[gnt_cpu] = 1'b0;
                    else          bus.iwait[gnt_cpu] = 1'b0;
                    state_n     = IDLE;
                    gnt_valid_n = 1'b0;
                    rr_ptr_n    = (int'(gnt_cpu) == CPUS - 1) ? '0 : gnt_cpu + 1'b1;
                end
            end
            ERR: begin
                if (ram_st != RAM_ERROR) begin
                    state_n     = IDLE;
                    gnt_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // A RAM error overrides everything: no new grant is taken and the pointer is preserved.
        if (ram_st == RAM_ERROR) begin
            state_n     = ERR;
            gnt_valid_n = 1'b0;
            gnt_cpu_n   = gnt_cpu;
            gnt_data_n  = gnt_data;
            rr_ptr_n    = rr_ptr;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_cpu   <= '0;
            gnt_data  <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_n;
            gnt_valid <= gnt_valid_n;
            gnt_cpu   <= gnt_cpu_n;
            gnt_data  <= gnt_data_n;
            rr_ptr    <= rr_ptr_n;
        end
    end

    assign bus.grant_valid = gnt_valid;
    assign bus.grant_cpu   = gnt_cpu;
    assign bus.grant_data  = gnt_data;
    assign bus.iload       = bus.ramload;
    assign bus.dload       = bus.ramload;
endmodule

// File: tb/tb_ram_request_arbiter.sv
// Bench for ram_request_arbiter: directed scenarios first, then random per-core request streams
// against a transaction-level scoreboard and a round-robin ordering model.
module tb_ram_request_arbiter;
    localparam int CPUS  = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int N_TXN = 40;
    localparam int LIMIT = 20000;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    ram_request_arbiter_if #(.CPUS(CPUS), .AW(AW), .DW(DW)) bus ();

    ram_request_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_d(input int c, input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d);
        bus.dREN[c]            = ren;
        bus.dWEN[c]            = wen;
        bus.daddr[c*AW +: AW]  = a;
        bus.dstore[c*DW +: DW] = d;
    endtask

    task automatic set_i(input int c, input logic ren, input logic [31:0] a);
        bus.iREN[c]           = ren;
        bus.iaddr[c*AW +: AW] = a;
    endtask

    // Scoreboard: one expected-transfer queue per core and request kind.
    txn_t dq [CPUS][$];
    txn_t iq [CPUS][$];
    int   iss_d [CPUS];
    int   iss_i [CPUS];
    int   comp_d [CPUS];
    int   comp_i [CPUS];
    bit   rand_on = 1'b0;
    int   model_rr;
    logic [CPUS-1:0] prev_any, prev_data;
    logic prev_gv;

    // Monitor: pops and compares whenever a wait drops; checks grant order on every new grant.
    txn_t e;
    int   w, idx, lows;
    initial begin
        forever begin
            @(negedge CLK);
            if (rand_on) begin
                lows = 0;
                if (bus.grant_valid && !prev_gv) begin
                    w = -1;
                    for (int k = 0; k < CPUS; k++) begin
                        idx = (model_rr + k) % CPUS;
                        if (w < 0 && prev_any[idx]) w = idx;
                    end
                    check("rr_grant_cpu", bus.grant_cpu, w);
                    if (w >= 0) check("grant_data_prio", bus.grant_data, prev_data[w]);
                end
                for (int c = 0; c < CPUS; c++) begin
                    if (!bus.dwait[c]) begin
                        lows++;
                        if (dq[c].size() == 0) check("dwait_spurious", dq[c].size(), 1);
                        else begin
                            e = dq[c].pop_front();
                            check("d_owner", bus.grant_cpu, c);
                            check("d_wen", bus.ramWEN, e.we);
                            check("d_ren", bus.ramREN, !e.we);
                            check("d_addr", bus.ramaddr, e.addr);
                            if (e.we) check("d_store", bus.ramstore, e.data);
                            else      check("d_load", bus.dload, ram_word(e.addr));
                            comp_d[c]++;
                            model_rr = (c + 1) % CPUS;
                        end
                    end
                    if (!bus.iwait[c]) begin
                        lows++;
                        if (iq[c].size() == 0) check("iwait_spurious", iq[c].size(), 1);
                        else begin
                            e = iq[c].pop_front();
                            check("i_owner", bus.grant_cpu, c);
                            check("i_ren", {bus.ramREN, bus.ramWEN}, 2'b10);
                            check("i_addr", bus.ramaddr, e.addr);
                            check("i_load", bus.iload, ram_word(e.addr));
                            comp_i[c]++;
                            model_rr = (c + 1) % CPUS;
                        end
                    end
                end
                if (lows > 0) check("single_wait_low", lows, 1);
                prev_any  = bus.iREN | bus.dREN | bus.dWEN;
                prev_data = bus.dREN | bus.dWEN;
                prev_gv   = bus.grant_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    txn_t ne;
    int   cyc, busy_left, grants, exp_c, total_done;
    initial begin
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramstate = FREE; bus.ramload = 32'hCAFE_F00D;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_grant", {bus.grant_valid, bus.grant_cpu, bus.grant_data}, 3'b000);
        check("rst_en", {bus.ramREN, bus.ramWEN}, 2'b00);
        check("rst_addr_store", {bus.ramaddr, bus.ramstore}, 64'h0);
        check("rst_waits", {bus.iwait, bus.dwait}, 4'hF);
        tick();
        nRST = 1'b1;

        // Core0 data read then its instruction fetch, RAM answering immediately.
        set_d(0, 1'b1, 1'b0, 32'h100, 32'h0);
        set_i(0, 1'b1, 32'h40);
        bus.ramstate = ACCESS;
        @(negedge CLK);
        check("A_idle_no_en", {bus.ramREN, bus.ramWEN}, 2'b00);
        tick();
        @(negedge CLK);
        check("A_d_ren", {bus.ramREN, bus.ramWEN}, 2'b10);
        check("A_d_addr", bus.ramaddr, 32'h100);
        check("A_d_waits", {bus.iwait, bus.dwait}, 4'b1110);
        check("A_dload", bus.dload, 32'hCAFE_F00D);
        tick();
        set_d(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        check("A_gap", {bus.grant_valid, bus.ramREN}, 2'b00);
        tick();
        @(negedge CLK);
        check("A_i_addr", bus.ramaddr, 32'h40);
        check("A_i_waits", {bus.iwait, bus.dwait}, 4'b1011);
        check("A_iload", bus.iload, 32'hCAFE_F00D);
        tick();
        set_i(0, 1'b0, 32'h0);

        // Reset while core1 holds a write grant.
        set_d(1, 1'b0, 1'b1, 32'h880, 32'hDEAD_BEEF);
        bus.ramstate = BUSY;
        tick();
        @(negedge CLK);
        check("B_wen", {bus.ramWEN, bus.grant_cpu}, 2'b11);
        check("B_store", {bus.ramaddr, bus.ramstore}, {32'h880, 32'hDEAD_BEEF});
        #2 nRST = 1'b0;
        #1;
        check("B_rst_en", {bus.ramREN, bus.ramWEN, bus.grant_valid}, 3'b000);
        check("B_rst_waits", {bus.iwait, bus.dwait}, 4'hF);
        set_d(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        nRST = 1'b1;

        // Both cores writing continuously: grants alternate starting with core0.
        bus.ramstate = ACCESS;
        set_d(0, 1'b0, 1'b1, 32'h200, 32'hAAAA_5555);
        set_d(1, 1'b0, 1'b1, 32'h300, 32'h1234_5678);
        exp_c = 0;
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (bus.ramWEN) begin
                check("C_owner", bus.grant_cpu, exp_c);
                check("C_addr", bus.ramaddr, (exp_c == 1) ? 32'h300 : 32'h200);
                check("C_store", bus.ramstore, (exp_c == 1) ? 32'h1234_5678 : 32'hAAAA_5555);
                grants++;
                exp_c ^= 1;
            end
        end
        check("C_grant_count", grants, 6);
        tick();
        set_d(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_d(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Core1 fetch with three BUSY cycles before ACCESS.
        bus.ramstate = BUSY;
        set_i(1, 1'b1, 32'h8);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) bus.ramstate = ACCESS;
            @(negedge CLK);
            check("D_ren", {bus.ramREN, bus.ramaddr}, {1'b1, 32'h8});
            check("D_waits", {bus.iwait, bus.dwait}, (k == 4) ? 4'b0111 : 4'b1111);
        end
        tick();
        set_i(1, 1'b0, 32'h0);
        bus.ramstate = FREE;

        // Core0 drops its read after one BUSY cycle; pointer stays on core0.
        set_d(0, 1'b1, 1'b0, 32'h500, 32'h0);
        bus.ramstate = BUSY;
        tick();
        @(negedge CLK);
        check("E_busy", {bus.ramREN, bus.dwait}, 3'b111);
        tick();
        set_d(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        check("E_drop_waits", {bus.iwait, bus.dwait}, 4'hF);
        tick();
        set_d(0, 1'b1, 1'b0, 32'h600, 32'h0);
        set_d(1, 1'b1, 1'b0, 32'h700, 32'h0);
        bus.ramstate = ACCESS;
        @(negedge CLK);
        check("E_idle", bus.grant_valid, 1'b0);
        tick();
        @(negedge CLK);
        check("E_core0_first", {bus.grant_cpu, bus.ramaddr}, {1'b0, 32'h600});
        check("E_core0_wait", {bus.iwait, bus.dwait}, 4'b1110);
        tick();
        set_d(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        @(negedge CLK);
        check("E_core1_next", {bus.grant_cpu, bus.ramaddr}, {1'b1, 32'h700});
        check("E_core1_wait", {bus.iwait, bus.dwait}, 4'b1101);
        tick();
        set_d(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // RAM error mid-grant for two cycles, then the pending write is granted again.
        set_d(0, 1'b0, 1'b1, 32'h900, 32'h5555_AAAA);
        bus.ramstate = BUSY;
        tick();
        @(negedge CLK);
        check("F_wen", bus.ramWEN, 1'b1);
        tick();
        bus.ramstate = ERROR;
        @(negedge CLK);
        check("F_err1_waits", {bus.iwait, bus.dwait}, 4'hF);
        tick();
        @(negedge CLK);
        check("F_err2_en", {bus.ramREN, bus.ramWEN, bus.grant_valid}, 3'b000);
        check("F_err2_waits", {bus.iwait, bus.dwait}, 4'hF);
        tick();
        bus.ramstate = FREE;
        @(negedge CLK);
        check("F_leave_en", {bus.ramREN, bus.ramWEN}, 2'b00);
        tick();
        bus.ramstate = ACCESS;
        @(negedge CLK);
        check("F_idle", {bus.ramREN, bus.ramWEN, bus.grant_valid}, 3'b000);
        tick();
        @(negedge CLK);
        check("F_regrant", {bus.ramWEN, bus.ramaddr, bus.ramstore}, {1'b1, 32'h900, 32'h5555_AAAA});
        check("F_regrant_wait", {bus.iwait, bus.dwait}, 4'b1110);
        tick();
        set_d(0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.ramstate = FREE;

        // Random phase: independent data and fetch streams per core, RAM with random BUSY latency.
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        model_rr  = 0;
        prev_any  = '0;
        prev_data = '0;
        prev_gv   = 1'b0;
        busy_left = 0;
        for (int c = 0; c < CPUS; c++) begin
            iss_d[c] = 0; iss_i[c] = 0; comp_d[c] = 0; comp_i[c] = 0;
        end
        rand_on = 1'b1;
        cyc = 0;
        total_done = 0;
        while (cyc < LIMIT && total_done < 2 * CPUS * N_TXN) begin
            tick();
            for (int c = 0; c < CPUS; c++) begin
                if (iss_d[c] == comp_d[c]) begin
                    if (iss_d[c] < N_TXN && $urandom_range(0, 2) != 0) begin
                        ne.we   = 1'($urandom_range(0, 1));
                        ne.addr = $urandom & 32'h0000_FFFC;
                        ne.data = $urandom;
                        set_d(c, ne.we ? 1'($urandom_range(0, 1)) : 1'b1, ne.we, ne.addr, ne.data);
                        dq[c].push_back(ne);
                        iss_d[c]++;
                    end else begin
                        set_d(c, 1'b0, 1'b0, 32'h0, 32'h0);
                    end
                end
                if (iss_i[c] == comp_i[c]) begin
                    if (iss_i[c] < N_TXN && $urandom_range(0, 2) != 0) begin
                        ne.we   = 1'b0;
                        ne.addr = $urandom & 32'h0000_FFFC;
                        ne.data = 32'h0;
                        set_i(c, 1'b1, ne.addr);
                        iq[c].push_back(ne);
                        iss_i[c]++;
                    end else begin
                        set_i(c, 1'b0, 32'h0);
                    end
                end
            end
            #1;
            if (bus.ramREN || bus.ramWEN) begin
                if (busy_left > 0) begin
                    bus.ramstate = BUSY;
                    busy_left--;
                end else begin
                    bus.ramstate = ACCESS;
                end
                bus.ramload = ram_word(bus.ramaddr);
            end else begin
                bus.ramstate = FREE;
                bus.ramload  = 32'h0;
                busy_left    = $urandom_range(0, 3);
            end
            cyc++;
            total_done = 0;
            for (int c = 0; c < CPUS; c++) total_done += comp_d[c] + comp_i[c];
        end
        check("rand_all_served", total_done, 2 * CPUS * N_TXN);
        rand_on = 1'b0;
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_request_arbiter.md
Name: ram_request_arbiter

Overview:
- Shares the single RAM port between CPUS cores; each core presents instruction-fetch and data requests.
- Registered-grant arbiter: round-robin between cores, data-over-instruction priority within a core.
- One transfer is granted at a time and held until RAM reports ACCESS.
- Sits between the per-core cache control interfaces and the RAM model; drives the RAM enables, address and store data, and returns the per-requester wait signals.

Parameters:
CPUS, 2, number of cores arbitrated (≥1)
AW, 32, address width
DW, 32, data width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  CPUS  instruction read request per core
dREN  in  CPUS  data read request per core
dWEN  in  CPUS  data write request per core
iaddr  in  CPUS*AW  instruction address, core c at [c*AW +: AW]
daddr  in  CPUS*AW  data address, same packing
dstore  in  CPUS*DW  data write value, same packing
iwait  out  CPUS  instruction wait per core
dwait  out  CPUS  data wait per core
iload  out  DW  RAM read data, broadcast (= ramload)
dload  out  DW  RAM read data, broadcast (= ramload)
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  AW  RAM address
ramstore  out  DW  RAM write data
ramload  in  DW  RAM read data
ramstate  in  2  cpu_types_pkg ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
grant_valid  out  1  a grant is held
grant_cpu  out  clog2(max(CPUS,2))  core owning the grant
grant_data  out  1  1 = data grant, 0 = instruction grant

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE, grant_valid=0, grant_cpu=0, grant_data=0, rr_ptr=0.
  - ramREN=ramWEN=0; ramaddr=0, ramstore=0.
  - All iwait/dwait=1.
- States: IDLE, GRANT, ERR.
- IDLE:
  - Search cores starting at rr_ptr, incrementing modulo CPUS.
  - First core with dREN|dWEN|iREN wins.
  - Within the winning core, data (dREN|dWEN) beats iREN.
  - On a winner: register grant_cpu and grant_data, set grant_valid, go to GRANT next cycle.
  - RAM enables stay 0 while in IDLE.
- GRANT, data grant:
  - dWEN=1: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
  - Otherwise: ramREN=1, ramaddr=daddr[g].
  - dWEN wins if dREN and dWEN are both high.
- GRANT, instruction grant: ramREN=1, ramaddr=iaddr[g].
- GRANT, completion:
  - RAM signals are driven from the owner's live inputs each cycle.
  - When ramstate==ACCESS: combinationally deassert the owner's granted wait (dwait[g] or iwait[g]) that cycle.
  - Next state is IDLE, grant_valid→0, rr_ptr←(g+1) mod CPUS.
- GRANT, abort: if the owner drops the granted request before ACCESS, go to IDLE next cycle, grant_valid→0, rr_ptr unchanged. No wait is deasserted.
- ERR:
  - Entered from any state when ramstate==ERROR.
  - Enables are 0, all waits are 1.
  - Leave to IDLE once ramstate≠ERROR; grant_valid is cleared and rr_ptr is unchanged.
- Waits: every iwait/dwait is 1 except the single completion case above. A non-granted requester always sees wait=1.
- Latency: request sampled in cycle N (IDLE) → enable asserted in N+1. With RAM returning ACCESS at the first GRANT cycle, wait drops in N+1. Minimum 2 cycles per transfer, so back-to-back transfers complete every 2 cycles.
- Simultaneous requests: at most one grant per IDLE cycle; the loser's wait stays 1 until it is served.
- Fairness: with all cores requesting continuously, every core is served within CPUS grants.
- iload/dload: purely combinational copies of ramload.
- Reset mid-transfer: outputs return to reset values immediately; the transfer is dropped.

Test Plan:
- Reset during GRANT with ramWEN=1 → ramWEN=0, all waits=1 and grant_valid=0 in the same cycle nRST falls.
- Core0 dREN=1, daddr=0x100, iREN=1, iaddr=0x40, RAM ACCESS on first GRANT cycle →
  - Cycle 1: ramREN=1, ramaddr=0x100, dwait[0]=0 in that cycle.
  - Instruction fetch granted next: ramaddr=0x40, iwait[0]=0 two cycles later.
- Both cores dWEN=1 continuously (daddr 0x200/0x300, dstore 0xAAAA5555/0x12345678), RAM ACCESS every grant → grants alternate core0, core1, core0…, and each ramstore/ramaddr matches the owner.
- RAM BUSY 3 cycles then ACCESS for core1 iREN, iaddr=0x8 → ramREN=1 held 4 cycles and iwait[1]=0 only in the 4th; core0 waits stay 1 throughout.
- Core0 dREN granted, dropped after 1 BUSY cycle → IDLE next cycle, no wait deasserted, rr_ptr stays 0 so core0 wins the next simultaneous request.
- ramstate=ERROR mid-grant for 2 cycles → enables=0, all waits=1; on FREE the arbiter returns to IDLE and the pending request is re-granted.
